// File: rtl/jtpopeye_busarb_pkg.sv
// jtpopeye_busarb_pkg: shared types and constants for the Popeye DMA bus arbiter.
//   busarb_st_t       arbiter FSM state encoding
//   BUSARB_WDOG_W/MAX grant watchdog counter width and terminal count
//   busarb_dma_owns   true in states where the DMA side owns the work RAM
package jtpopeye_busarb_pkg;

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } busarb_st_t;

    localparam int unsigned BUSARB_WDOG_W = 12;
    localparam logic [BUSARB_WDOG_W-1:0] BUSARB_WDOG_MAX = 12'd4095;

    // RELEASE keeps the RAM on the DMA side so the CPU cannot write during the guard period
    function automatic logic busarb_dma_owns(input busarb_st_t st);
        return (st == ST_GRANT) || (st == ST_RELEASE);
    endfunction

endpackage

// File: rtl/jtpopeye_busarb_if.sv
// jtpopeye_busarb_if: CPU, DMA and work-RAM signals around the bus arbiter.
//   slave  : arbiter view (drives busak_n, cpu_hold, dma_dm, ram_*, wdog_err)
//   master : environment view (CPU core, DMA engine, work RAM)
interface jtpopeye_busarb_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8
);
    logic          busrq_n;
    logic          busak_n;
    logic          cpu_mreq_n;
    logic          cpu_iorq_n;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic          cpu_we;
    logic          cpu_hold;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_dm;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic          wdog_err;

    modport slave (
        input  busrq_n, cpu_mreq_n, cpu_iorq_n, cpu_addr, cpu_dout, cpu_we,
               dma_addr, ram_q,
        output busak_n, cpu_hold, dma_dm, ram_addr, ram_din, ram_we, wdog_err
    );

    modport master (
        output busrq_n, cpu_mreq_n, cpu_iorq_n, cpu_addr, cpu_dout, cpu_we,
               dma_addr, ram_q,
        input  busak_n, cpu_hold, dma_dm, ram_addr, ram_din, ram_we, wdog_err
    );
endinterface

// File: rtl/jtpopeye_busarb_wdog.sv
// jtpopeye_busarb_wdog: grant-timeout counter.
//   clk, rst_n   clock, synchronous active-low reset
//   i_cen        CPU clock-enable strobe
//   i_active     high while the arbiter is in GRANT; low clears the count
//   o_expire_c   combinational: this strobe brings the count to BUSARB_WDOG_MAX
module jtpopeye_busarb_wdog (
    input  logic clk,
    input  logic rst_n,
    input  logic i_cen,
    input  logic i_active,
    output logic o_expire_c
);
    import jtpopeye_busarb_pkg::*;

    logic [BUSARB_WDOG_W-1:0] r_cnt;

    // Counts strobes spent in GRANT, saturating at the terminal count
    always_ff @(posedge clk) begin
        if (!rst_n || !i_active) begin
            r_cnt <= '0;
        end else if (i_cen && (r_cnt != BUSARB_WDOG_MAX)) begin
            r_cnt <= r_cnt + BUSARB_WDOG_W'(1);
        end
    end

    // Fires on the strobe whose increment reaches the terminal count
    assign o_expire_c = i_active && i_cen &&
                        (r_cnt == (BUSARB_WDOG_MAX - BUSARB_WDOG_W'(1)));

endmodule

// File: rtl/jtpopeye_busarb.sv
// jtpopeye_busarb: Popeye sprite-DMA bus arbiter and work-RAM responder.
// Drains the current CPU cycle, acknowledges BUSRQn, holds the CPU and steers the
// DMA address onto the 1 KB work RAM; RAM read data returns on dma_dm.
//   clk, rst_n   clock, synchronous active-low reset
//   cpu_cen      CPU clock-enable strobe; all arbitration decisions happen on it
//   bus          jtpopeye_busarb_if.slave (CPU, DMA and RAM signals)
// Optional: define JTPOPEYE_BUSARB_WDOG_EN to force a release after 4095 strobes
// in GRANT and raise the sticky wdog_err flag.
module jtpopeye_busarb #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_cen,
    jtpopeye_busarb_if.slave    bus
);
    import jtpopeye_busarb_pkg::*;

    busarb_st_t    r_state;
    logic          r_busak_n;
    logic          r_cpu_hold;
    logic [DW-1:0] r_dma_dm;

    logic          w_cpu_idle;
    logic          w_dma_owns;
    logic          w_in_grant;
    logic          w_wdog_hit;
    logic [AW-1:0] w_ram_addr;

    assign w_cpu_idle = bus.cpu_mreq_n & bus.cpu_iorq_n;
    assign w_in_grant = (r_state == ST_GRANT);
    // Reset hands the RAM straight back to the CPU port
    assign w_dma_owns = rst_n && busarb_dma_owns(r_state);

    // Arbitration FSM with registered acknowledge, hold and DMA read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_CPU;
            r_busak_n  <= 1'b1;
            r_cpu_hold <= 1'b0;
            r_dma_dm   <= '0;
        end else begin
            if (w_in_grant) begin
                r_dma_dm <= bus.ram_q;
            end
            if (cpu_cen) begin
                case (r_state)
                    ST_CPU: begin
                        // A cycle starting on the same strobe counts as busy
                        if (!bus.busrq_n) begin
                            if (w_cpu_idle) begin
                                r_state    <= ST_GRANT;
                                r_busak_n  <= 1'b0;
                                r_cpu_hold <= 1'b1;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (bus.busrq_n) begin
                            r_state <= ST_CPU;
                        end else if (w_cpu_idle) begin
                            r_state    <= ST_GRANT;
                            r_busak_n  <= 1'b0;
                            r_cpu_hold <= 1'b1;
                        end
                    end
                    ST_GRANT: begin
                        if (bus.busrq_n || w_wdog_hit) begin
                            r_state   <= ST_RELEASE;
                            r_busak_n <= 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        // Guard period: requests are only seen again from CPU
                        r_state    <= ST_CPU;
                        r_cpu_hold <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_CPU;
                    end
                endcase
            end
        end
    end

`ifdef JTPOPEYE_BUSARB_WDOG_EN
    logic r_wdog_err;

    jtpopeye_busarb_wdog u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cen      (cpu_cen),
        .i_active   (w_in_grant),
        .o_expire_c (w_wdog_hit)
    );

    // Sticky until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog_err <= 1'b0;
        end else if (w_wdog_hit) begin
            r_wdog_err <= 1'b1;
        end
    end

    assign bus.wdog_err = r_wdog_err;
`else
    assign w_wdog_hit   = 1'b0;
    assign bus.wdog_err = 1'b0;
`endif

    // Work-RAM port steering
    assign w_ram_addr   = w_dma_owns ? bus.dma_addr : bus.cpu_addr;
    assign bus.ram_addr = w_ram_addr;
    assign bus.ram_din  = bus.cpu_dout;
    assign bus.ram_we   = w_dma_owns ? 1'b0 : bus.cpu_we;

    assign bus.busak_n  = r_busak_n;
    assign bus.cpu_hold = r_cpu_hold;
    assign bus.dma_dm   = r_dma_dm;

endmodule
